// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: instruction field layout, reservation-station class
// select and the register status entry used by the rename table.
package tomasulo_pkg;

   localparam int OP_W      = 4;
   localparam int REG_AW    = 4;
   localparam int INSTR_W   = 16;
   localparam int TAG_MAX_W = 8;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 8;
   localparam int RS1_MSB = 7;
   localparam int RS1_LSB = 4;
   localparam int RS2_MSB = 3;
   localparam int RS2_LSB = 0;

   // Tag field is sized for the widest supported ROB; narrower tags are zero-extended.
   typedef struct packed {
      logic                 busy;
      logic [TAG_MAX_W-1:0] tag;
   } reg_stat_t;

   // Reservation-station group is op[sel_w:1]; op[0] selects a variant within a group.
   function automatic int unsigned rs_class(input logic [OP_W-1:0] op, input int unsigned sel_w);
      int unsigned mask;
      mask = (32'd1 << sel_w) - 32'd1;
      return (32'(op) >> 1) & mask;
   endfunction

endpackage

// File: rtl/dispatch_unit_if.sv
// Fetch handshake plus ROB-allocate and reservation-station dispatch bus of the dispatch stage.
// master = fetch/ROB/RS side, slave = dispatch_unit.
interface dispatch_unit_if #(
   parameter int NUM_RS = 2,
   parameter int DATA_W = 8,
   parameter int TAG_W  = 2
);
   import tomasulo_pkg::*;

   logic                in_valid;
   logic [INSTR_W-1:0]  in_instr;
   logic                in_ready;

   logic                rob_alloc_ready;
   logic [TAG_W-1:0]    rob_alloc_tag;
   logic                rob_alloc_valid;
   logic [OP_W-1:0]     rob_alloc_op;
   logic [REG_AW-1:0]   rob_alloc_dest;

   logic [NUM_RS-1:0]   rs_ready;
   logic [NUM_RS-1:0]   rs_valid;
   logic [OP_W-1:0]     rs_op;
   logic [TAG_W-1:0]    rs_tag;
   logic                rs_v1;
   logic [TAG_W-1:0]    rs_q1;
   logic [DATA_W-1:0]   rs_val1;
   logic                rs_v2;
   logic [TAG_W-1:0]    rs_q2;
   logic [DATA_W-1:0]   rs_val2;

   modport master (
      output in_valid, in_instr, rob_alloc_ready, rob_alloc_tag, rs_ready,
      input  in_ready, rob_alloc_valid, rob_alloc_op, rob_alloc_dest,
             rs_valid, rs_op, rs_tag, rs_v1, rs_q1, rs_val1, rs_v2, rs_q2, rs_val2
   );

   modport slave (
      input  in_valid, in_instr, rob_alloc_ready, rob_alloc_tag, rs_ready,
      output in_ready, rob_alloc_valid, rob_alloc_op, rob_alloc_dest,
             rs_valid, rs_op, rs_tag, rs_v1, rs_q1, rs_val1, rs_v2, rs_q2, rs_val2
   );

endinterface

// File: rtl/dispatch_unit_iq.sv
// dispatch_iq: circular instruction queue (power-of-2 depth) with push, pop and flush.
// Storage is not reset; only head/tail/count are.
module dispatch_iq #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [W-1:0]               i_wdata,
   output logic [W-1:0]               o_rdata,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [AW:0]   r_count;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_tail <= r_tail + 1'b1;
         if (i_pop)  r_head <= r_head + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_tail] <= i_wdata;
   end

   assign o_rdata = r_mem[r_head];
   assign o_count = r_count;

endmodule

// File: rtl/dispatch_unit.sv
// dispatch_unit: in-order instruction queue, decode, register rename and operand resolution.
// Optional CDB-to-operand bypass at dispatch is enabled by defining DISPATCH_CDB_BYPASS_EN.
module dispatch_unit
   import tomasulo_pkg::*;
#(
   parameter int IQ_DEPTH = 4,
   parameter int NUM_RS   = 2,
   parameter int DATA_W   = 8,
   parameter int TAG_W    = 2,
   parameter int NREGS    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   dispatch_unit_if.slave            bus,
   output logic [REG_AW-1:0]         rf_rd_addr1,
   output logic [REG_AW-1:0]         rf_rd_addr2,
   input  logic [DATA_W-1:0]         rf_rd_data1,
   input  logic [DATA_W-1:0]         rf_rd_data2,
   input  logic                      cdb_valid,
   input  logic [TAG_W-1:0]          cdb_tag,
   input  logic [DATA_W-1:0]         cdb_data,
   input  logic                      commit_valid,
   input  logic [REG_AW-1:0]         commit_dest,
   input  logic [TAG_W-1:0]          commit_tag,
   input  logic [DATA_W-1:0]         commit_data,
   output logic [$clog2(IQ_DEPTH):0] iq_count
);

   localparam int SEL_W = $clog2(NUM_RS);
   localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

   typedef struct packed {
      logic              v;
      logic [TAG_W-1:0]  q;
      logic [DATA_W-1:0] val;
   } opnd_t;

   reg_stat_t          r_stat [NREGS];

   logic [INSTR_W-1:0] w_head;
   logic [CNT_W-1:0]   w_count;
   logic [OP_W-1:0]    w_op;
   logic [REG_AW-1:0]  w_rd;
   logic [REG_AW-1:0]  w_rs1;
   logic [REG_AW-1:0]  w_rs2;
   logic [SEL_W-1:0]   w_class;
   logic               w_in_ready;
   logic               w_push;
   logic               w_fire;
   logic [NUM_RS-1:0]  w_rs_valid;
   opnd_t              w_opnd1;
   opnd_t              w_opnd2;

   assign w_in_ready = (w_count != CNT_W'(IQ_DEPTH));
   assign w_push     = bus.in_valid && w_in_ready && !flush;

   dispatch_iq #(
      .DEPTH (IQ_DEPTH),
      .W     (INSTR_W)
   ) u_iq (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (flush),
      .i_push  (w_push),
      .i_pop   (w_fire),
      .i_wdata (bus.in_instr),
      .o_rdata (w_head),
      .o_count (w_count)
   );

   assign w_op    = w_head[OP_MSB:OP_LSB];
   assign w_rd    = w_head[RD_MSB:RD_LSB];
   assign w_rs1   = w_head[RS1_MSB:RS1_LSB];
   assign w_rs2   = w_head[RS2_MSB:RS2_LSB];
   assign w_class = SEL_W'(rs_class(w_op, SEL_W));

   assign w_fire = !flush && (w_count != '0) && bus.rob_alloc_ready && bus.rs_ready[w_class];

   always_comb begin
      w_rs_valid          = '0;
      w_rs_valid[w_class] = w_fire;
   end

   // Status is read before this cycle's rename, so rd==rs sees the older producer.
   function automatic opnd_t resolve(input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] rf_data);
      opnd_t o;
      o.v   = 1'b0;
      o.q   = r_stat[r].tag[TAG_W-1:0];
      o.val = '0;
      if (!r_stat[r].busy) begin
         o.v   = 1'b1;
         o.val = rf_data;
      end else if (commit_valid && (commit_dest == r) &&
                   (TAG_MAX_W'(commit_tag) == r_stat[r].tag)) begin
         o.v   = 1'b1;
         o.val = commit_data;
      end
`ifdef DISPATCH_CDB_BYPASS_EN
      else if (cdb_valid && (TAG_MAX_W'(cdb_tag) == r_stat[r].tag)) begin
         o.v   = 1'b1;
         o.val = cdb_data;
      end
`endif
      return o;
   endfunction

`ifndef DISPATCH_CDB_BYPASS_EN
   // Without bypass the CDB is only snooped by the reservation stations.
   logic w_unused_cdb;
   assign w_unused_cdb = ^{cdb_valid, cdb_tag, cdb_data};
`endif

   always_comb begin
      w_opnd1 = resolve(w_rs1, rf_rd_data1);
      w_opnd2 = resolve(w_rs2, rf_rd_data2);
   end

   // A rename in the same cycle as a commit to that register must win, so it is written last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) r_stat[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < NREGS; i++) r_stat[i].busy <= 1'b0;
      end else begin
         if (commit_valid && (r_stat[commit_dest].tag == TAG_MAX_W'(commit_tag)))
            r_stat[commit_dest].busy <= 1'b0;
         if (w_fire) begin
            r_stat[w_rd].busy <= 1'b1;
            r_stat[w_rd].tag  <= TAG_MAX_W'(bus.rob_alloc_tag);
         end
      end
   end

   assign bus.in_ready        = w_in_ready;
   assign bus.rob_alloc_valid = w_fire;
   assign bus.rob_alloc_op    = w_op;
   assign bus.rob_alloc_dest  = w_rd;
   assign bus.rs_valid        = w_rs_valid;
   assign bus.rs_op           = w_op;
   assign bus.rs_tag          = bus.rob_alloc_tag;
   assign bus.rs_v1           = w_opnd1.v;
   assign bus.rs_q1           = w_opnd1.q;
   assign bus.rs_val1         = w_opnd1.val;
   assign bus.rs_v2           = w_opnd2.v;
   assign bus.rs_q2           = w_opnd2.q;
   assign bus.rs_val2         = w_opnd2.val;

   assign rf_rd_addr1 = w_rs1;
   assign rf_rd_addr2 = w_rs2;
   assign iq_count    = w_count;

endmodule
